// File: rtl/fifo_pkg.sv
// Shared types and constants for the dual-clock FIFO read-side logic.
package fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 8;
   localparam int unsigned STATS_W            = 16;
   localparam int unsigned BUF_DEPTH          = 2;

   typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;
   typedef logic [1:0]                    occ_t;

   // Saturating increment for the stall statistic.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (&v) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Valid/ready stream carrying FIFO words from the read adapter to downstream logic.
interface fifo_rd_stream_adapter_if
   import fifo_pkg::*;
#(
   parameter int unsigned data_width_p = DATA_WIDTH_DEFAULT
);

   logic                    m_valid;
   logic                    m_ready;
   logic [data_width_p-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/stream_skid_buf2.sv
// Two-entry output buffer: captures returning FIFO words, presents the head word, drops on flush.
module stream_skid_buf2
   import fifo_pkg::*;
#(
   parameter int unsigned data_width_p = DATA_WIDTH_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    capture_i,
   input  logic [data_width_p-1:0] wdata_i,
   input  logic                    pop_i,
   output logic [data_width_p-1:0] rdata_o,
   output logic                    valid_o,
   output occ_t                    count_o
);

   logic [data_width_p-1:0] mem_q [2];
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;
   occ_t                    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (capture_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)     rd_ptr_d = ~rd_ptr_q;
         case ({capture_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is reset so the head word reads as zero out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (capture_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (count_q != 2'd0);
   assign count_o = count_q;

`ifndef SYNTHESIS
   a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= 2'd2);
`endif

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO rd_en/empty/data_out port into a valid/ready stream in the read clock domain.
// Optional FIFO_RD_STREAM_STATS_EN adds word_cnt (wrapping) and stall_cnt (saturating) outputs.
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int unsigned data_width_p = DATA_WIDTH_DEFAULT,
   parameter int unsigned buf_depth_p  = BUF_DEPTH
) (
   input  logic                      rclk,
   input  logic                      rrst_n,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   input  logic [data_width_p-1:0]   fifo_data,
   input  logic                      flush,
   fifo_rd_stream_adapter_if.master  m_if,
   output logic [1:0]                occupancy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [STATS_W-1:0]        word_cnt,
   output logic [STATS_W-1:0]        stall_cnt
`endif
);

   if (buf_depth_p != BUF_DEPTH) begin : g_bad_depth
      $error("fifo_rd_stream_adapter: buf_depth_p must be 2");
   end

   logic                    inflight_q, inflight_d;
   logic                    pop;
   logic                    capture;
   logic                    buf_valid;
   logic [data_width_p-1:0] buf_rdata;
   occ_t                    count;
   logic [2:0]              pending;

   // Reads are issued only while buffered plus in-flight words, net of this cycle's pop,
   // leave room for one more; this keeps count + inflight <= 2 at all times.
   always_comb begin
      pop        = buf_valid & m_if.m_ready;
      pending    = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_rd_en = rrst_n & !fifo_empty & !flush & (pending < 3'd2);
      inflight_d = fifo_rd_en & !fifo_empty;
      capture    = inflight_q & !flush;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) inflight_q <= 1'b0;
      else         inflight_q <= inflight_d;
   end

   stream_skid_buf2 #(
      .data_width_p (data_width_p)
   ) u_buf (
      .clk_i     (rclk),
      .rst_ni    (rrst_n),
      .flush_i   (flush),
      .capture_i (capture),
      .wdata_i   (fifo_data),
      .pop_i     (pop),
      .rdata_o   (buf_rdata),
      .valid_o   (buf_valid),
      .count_o   (count)
   );

   assign m_if.m_valid = buf_valid;
   assign m_if.m_data  = buf_rdata;
   assign occupancy    = count;

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [STATS_W-1:0] word_cnt_q, word_cnt_d;
   logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      word_cnt_d  = word_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         word_cnt_d  = '0;
         stall_cnt_d = '0;
      end else begin
         if (pop)                        word_cnt_d  = word_cnt_q + STATS_W'(1);
         if (buf_valid && !m_if.m_ready) stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
   a_rd_en_nonempty: assert property (@(posedge rclk) disable iff (!rrst_n)
      fifo_rd_en |-> !fifo_empty);
   a_data_stable: assert property (@(posedge rclk) disable iff (!rrst_n)
      (m_if.m_valid && !m_if.m_ready && !flush) |=> $stable(m_if.m_data));
`endif

endmodule
